// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-side PS/2 frame transmitter with a small byte FIFO and host-inhibit retry.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int GAP_CYCLES  = 4000,
  parameter int DEPTH       = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic [7:0]               data_in,
  input  logic                     data_en,
  input  logic                     ps2_clk_in,
  output logic                     ps2_clk,
  output logic                     ps2_dat,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_done,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int MAXC = HALF_PERIOD > GAP_CYCLES ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, INHIBIT} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    idx_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [7:0]    head;
  logic [10:0]   frame;
  logic          hp_end, gap_end, pop, push;
  logic [AW:0]   count_d;
  // Head is only peeked while sending; it leaves the FIFO when the stop bit completes.
  assign head    = mem_q[rd_q];
  assign frame   = {1'b1, ~^head, head, 1'b0};
  assign hp_end  = cnt_q == CW'(HALF_PERIOD - 1);
  assign gap_end = cnt_q == CW'(GAP_CYCLES - 1);
  assign pop     = state_q == LOW && hp_end && idx_q == 4'd10;
  assign push    = data_en && (fifo_count != (AW+1)'(DEPTH) || pop);
  assign count_d = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_count <= '0;
      ps2_clk    <= 1'b1;
      ps2_dat    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= pop;
      overflow   <= overflow | (data_en & ~push);
      fifo_count <= count_d;
      if (push) begin
        mem_q[wr_q] <= data_in;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (!ps2_clk_in) begin
            state_q <= INHIBIT;
            busy    <= 1'b1;
          end else if (fifo_count != '0) begin
            state_q <= HIGH;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        end
        HIGH: begin
          // The first HIGH cycle ignores the line so our own release edge is not mistaken for inhibit.
          if (cnt_q != '0 && !ps2_clk_in) begin
            state_q <= INHIBIT;
            cnt_q   <= '0;
            ps2_clk <= 1'b1;
            ps2_dat <= 1'b1;
          end else begin
            if (cnt_q == '0) ps2_dat <= frame[idx_q];
            if (hp_end) begin
              state_q <= LOW;
              cnt_q   <= '0;
              ps2_clk <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
          end
        end
        LOW: begin
          if (hp_end) begin
            cnt_q   <= '0;
            ps2_clk <= 1'b1;
            if (idx_q == 4'd10) begin
              state_q <= GAP;
              ps2_dat <= 1'b1;
            end else begin
              state_q <= HIGH;
              idx_q   <= idx_q + 1'b1;
            end
          end else cnt_q <= cnt_q + 1'b1;
        end
        GAP: begin
          if (gap_end) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        INHIBIT: begin
          if (!ps2_clk_in) cnt_q <= '0;
          else if (hp_end) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
